// File: rtl/host_mem_sequencer_if.sv
// Bundles the load stream, dump stream and data-memory port of host_mem_sequencer.
// master = sequencer side, slave = stream source/sink plus memory side.
interface host_mem_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  in_valid, in_data,
        output in_ready,
        output out_valid, out_data,
        input  out_ready,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready,
        input  out_valid, out_data,
        output out_ready,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/host_mem_sequencer.sv
// Host-side sequencer: streams a program image into data memory, starts the cores,
// times them until every core has ended, then streams a memory window back out.
module host_mem_sequencer #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int LOAD_WORDS = 1000,
    parameter int DUMP_START = 0,
    parameter int DUMP_END   = 997,
    parameter int NUM_CORES  = 4,
    parameter int SETTLE_CYC = 20
) (
    input  logic                 clk,
    input  logic                 RESET_n,
    input  logic                 go,
    host_mem_sequencer_if.master bus,
    output logic [1:0]           addr_mux_select,
    output logic                 START,
    input  logic [NUM_CORES-1:0] core_end,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          run_cycles
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_SETTLE   = 3'd2;
    localparam logic [2:0] S_KICK     = 3'd3;
    localparam logic [2:0] S_RUN      = 3'd4;
    localparam logic [2:0] S_DUMP_RD  = 3'd5;
    localparam logic [2:0] S_DUMP_OUT = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [ADDR_W-1:0] LOAD_LAST   = ADDR_W'(LOAD_WORDS - 1);
    localparam logic [ADDR_W-1:0] SETTLE_LAST = ADDR_W'(SETTLE_CYC - 1);
    localparam logic [ADDR_W-1:0] DUMP_FIRST  = ADDR_W'(DUMP_START);
    localparam logic [ADDR_W-1:0] DUMP_LAST   = ADDR_W'(DUMP_END - 1);
    localparam bit                DUMP_EN     = (DUMP_END > DUMP_START);
    localparam bit                SETTLE_EN   = (SETTLE_CYC > 0);

    logic [2:0]           r_state;
    logic [ADDR_W-1:0]    r_ld_cnt;
    logic [ADDR_W-1:0]    r_settle_cnt;
    logic [ADDR_W-1:0]    r_dump_ptr;
    logic [NUM_CORES-1:0] r_end_flags;
    logic [31:0]          r_run_cycles;
    logic [DATA_W-1:0]    r_out_data;
    logic                 r_out_cap;

    logic [2:0]           w_next;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_all_end;

    assign w_in_fire  = (r_state == S_LOAD) && bus.in_valid;
    assign w_out_fire = (r_state == S_DUMP_OUT) && bus.out_ready;
    // A core counts as ended on the very cycle its END is seen, so pulses need not overlap.
    assign w_all_end  = &(r_end_flags | core_end);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (go) w_next = S_LOAD;
            S_LOAD: begin
                if (w_in_fire && (r_ld_cnt == LOAD_LAST))
                    w_next = SETTLE_EN ? S_SETTLE : S_KICK;
            end
            S_SETTLE:   if (r_settle_cnt == SETTLE_LAST) w_next = S_KICK;
            S_KICK:     w_next = S_RUN;
            S_RUN:      if (w_all_end) w_next = DUMP_EN ? S_DUMP_RD : S_DONE;
            S_DUMP_RD:  w_next = S_DUMP_OUT;
            S_DUMP_OUT: begin
                if (bus.out_ready)
                    w_next = (r_dump_ptr == DUMP_LAST) ? S_DONE : S_DUMP_RD;
            end
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state      <= S_IDLE;
            r_ld_cnt     <= '0;
            r_settle_cnt <= '0;
            r_dump_ptr   <= '0;
            r_end_flags  <= '0;
            r_run_cycles <= '0;
            r_out_data   <= '0;
            r_out_cap    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE, S_DONE: if (go) r_ld_cnt <= '0;
                S_LOAD: begin
                    r_settle_cnt <= '0;
                    if (w_in_fire) r_ld_cnt <= r_ld_cnt + ADDR_W'(1);
                end
                S_SETTLE: r_settle_cnt <= r_settle_cnt + ADDR_W'(1);
                S_KICK: begin
                    r_run_cycles <= '0;
                    r_end_flags  <= '0;
                    r_dump_ptr   <= DUMP_FIRST;
                end
                S_RUN: begin
                    r_end_flags <= r_end_flags | core_end;
                    if (r_run_cycles != '1) r_run_cycles <= r_run_cycles + 32'd1;
                end
                S_DUMP_RD: r_out_cap <= 1'b0;
                S_DUMP_OUT: begin
                    // Hold the read word so it stays stable even if the memory output moves during a stall.
                    if (!r_out_cap) begin
                        r_out_data <= bus.mem_rdata;
                        r_out_cap  <= 1'b1;
                    end
                    if (w_out_fire) r_dump_ptr <= r_dump_ptr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from state so an asynchronous reset clears them immediately.
    always_comb begin
        bus.in_ready    = (r_state == S_LOAD);
        bus.mem_we      = w_in_fire;
        bus.mem_wdata   = '0;
        bus.mem_addr    = '0;
        bus.out_valid   = (r_state == S_DUMP_OUT);
        bus.out_data    = '0;
        addr_mux_select = 2'd0;
        if (r_state == S_LOAD) begin
            bus.mem_addr    = r_ld_cnt;
            bus.mem_wdata   = bus.in_data;
            addr_mux_select = 2'd1;
        end
        if ((r_state == S_DUMP_RD) || (r_state == S_DUMP_OUT)) begin
            bus.mem_addr    = r_dump_ptr;
            addr_mux_select = 2'd2;
        end
        if (r_state == S_DUMP_OUT)
            bus.out_data = r_out_cap ? r_out_data : bus.mem_rdata;
    end

    assign START      = (r_state == S_KICK);
    assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done       = (r_state == S_DONE);
    assign run_cycles = r_run_cycles;

endmodule

// File: tb/tb_host_mem_sequencer.sv
// Scoreboard bench for host_mem_sequencer: directed load/run/dump sequences on two
// configurations (dump window 2..4 with SETTLE_CYC=3, and empty dump with SETTLE_CYC=0).
module tb_host_mem_sequencer;

    logic clk = 1'b0;
    logic RESET_n;
    logic mem_init;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // configuration A
    logic        goA;
    logic [1:0]  coreA;
    logic [1:0]  muxA;
    logic        startA, busyA, doneA;
    logic [31:0] runA;
    host_mem_sequencer_if #(.DATA_W(16), .ADDR_W(16)) busA ();

    host_mem_sequencer #(
        .DATA_W(16), .ADDR_W(16), .LOAD_WORDS(4), .DUMP_START(2), .DUMP_END(5),
        .NUM_CORES(2), .SETTLE_CYC(3)
    ) dutA (
        .clk(clk), .RESET_n(RESET_n), .go(goA), .bus(busA.master),
        .addr_mux_select(muxA), .START(startA), .core_end(coreA),
        .busy(busyA), .done(doneA), .run_cycles(runA)
    );

    // configuration B
    logic        goB;
    logic [1:0]  coreB;
    logic [1:0]  muxB;
    logic        startB, busyB, doneB;
    logic [31:0] runB;
    host_mem_sequencer_if #(.DATA_W(16), .ADDR_W(16)) busB ();

    host_mem_sequencer #(
        .DATA_W(16), .ADDR_W(16), .LOAD_WORDS(4), .DUMP_START(2), .DUMP_END(2),
        .NUM_CORES(2), .SETTLE_CYC(0)
    ) dutB (
        .clk(clk), .RESET_n(RESET_n), .go(goB), .bus(busB.master),
        .addr_mux_select(muxB), .START(startB), .core_end(coreB),
        .busy(busyB), .done(doneB), .run_cycles(runB)
    );

    // synchronous-read memory for A, preloaded with value == address
    logic [15:0] memA [0:15];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) memA[i] <= 16'(i);
        end else if (busA.mem_we && (muxA == 2'd1)) begin
            memA[busA.mem_addr[3:0]] <= busA.mem_wdata;
        end
        busA.mem_rdata <= memA[busA.mem_addr[3:0]];
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // scoreboard
    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t         exp_wr[$];
    logic [15:0] exp_out[$];

    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;
    logic        prev_start = 1'b0;
    int          last_wr_cyc = 0;
    int          seenB_out   = 0;

    always @(negedge clk) begin
        if (RESET_n === 1'b1) begin
            if (busA.mem_we) begin
                n_chk++;
                if (exp_wr.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_unexpected: got write addr %0d data %0d, expected none", busA.mem_addr, busA.mem_wdata);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", busA.mem_addr, e.a);
                    chk("wr_data", busA.mem_wdata, e.d);
                    chk("wr_mux", muxA, 2'd1);
                end
                last_wr_cyc = cyc;
            end
            if (startA) begin
                chk("start_gap", cyc - last_wr_cyc, 4);
                chk("start_mux", muxA, 2'd0);
                chk("start_width", prev_start, 1'b0);
            end
            if (busA.out_valid && prev_stall) chk("out_hold", busA.out_data, prev_data);
            if (busA.out_valid && busA.out_ready) begin
                n_chk++;
                if (exp_out.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_unexpected: got %0d, expected no word", busA.out_data);
                end else begin
                    chk("out_data", busA.out_data, exp_out.pop_front());
                end
            end
            prev_stall = busA.out_valid && !busA.out_ready;
            prev_data  = busA.out_data;
            prev_start = startA;
            if (busB.out_valid) seenB_out++;
        end else begin
            prev_stall = 1'b0;
            prev_start = 1'b0;
        end
    end

    // out_ready driver: toggles 1/0 when rdy_mode=1, held low otherwise
    logic rdy_mode = 1'b1;
    initial begin
        busA.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            busA.out_ready = rdy_mode ? ~busA.out_ready : 1'b0;
        end
    end

    task automatic pulse_goA();
        goA = 1'b1;
        @(posedge clk); #1;
        goA = 1'b0;
    endtask

    task automatic send_a(input logic [15:0] d);
        int t = 0;
        busA.in_valid = 1'b1;
        busA.in_data  = d;
        @(negedge clk);
        while (!busA.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("load_ready", busA.in_ready, 1'b1);
        @(posedge clk); #1;
        busA.in_valid = 1'b0;
        busA.in_data  = 16'hDEAD;
        @(posedge clk); #1;
    endtask

    task automatic load_a(input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3);
        exp_wr.push_back('{16'd0, d0});
        exp_wr.push_back('{16'd1, d1});
        exp_wr.push_back('{16'd2, d2});
        exp_wr.push_back('{16'd3, d3});
        send_a(d0);
        send_a(d1);
        send_a(d2);
        send_a(d3);
    endtask

    task automatic wait_startA();
        int t = 0;
        @(negedge clk);
        while (!startA && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("start_seen", startA, 1'b1);
    endtask

    // end pulses at START+5 and START+12; caller is at the negedge of the START cycle
    task automatic cores_a();
        repeat (5) @(posedge clk); #1;
        coreA = 2'b01;
        @(posedge clk); #1;
        coreA = 2'b00;
        repeat (6) @(posedge clk); #1;
        chk("run_after_first_end_mux", muxA, 2'd0);
        chk("run_after_first_end_busy", busyA, 1'b1);
        coreA = 2'b10;
        @(posedge clk); #1;
        coreA = 2'b00;
        chk("run_exit_mux", muxA, 2'd2);
        chk("run_cycles", runA, 32'd12);
    endtask

    task automatic wait_doneA();
        int t = 0;
        @(negedge clk);
        while (!doneA && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("done", doneA, 1'b1);
        chk("done_busy", busyA, 1'b0);
        chk("done_mux", muxA, 2'd0);
        chk("done_run_held", runA, 32'd12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        RESET_n       = 1'b0;
        mem_init      = 1'b1;
        goA           = 1'b0;
        coreA         = 2'b00;
        busA.in_valid = 1'b0;
        busA.in_data  = '0;
        goB           = 1'b0;
        coreB         = 2'b00;
        busB.in_valid = 1'b1;
        busB.in_data  = 16'd7;
        busB.out_ready = 1'b1;
        busB.mem_rdata = '0;
        @(posedge clk); #1;
        mem_init = 1'b0;
        chk("rst_busy", busyA, 1'b0);
        chk("rst_done", doneA, 1'b0);
        chk("rst_start", startA, 1'b0);
        chk("rst_mem_we", busA.mem_we, 1'b0);
        chk("rst_in_ready", busA.in_ready, 1'b0);
        chk("rst_out_valid", busA.out_valid, 1'b0);
        chk("rst_mux", muxA, 2'd0);
        chk("rst_mem_addr", busA.mem_addr, 16'd0);
        chk("rst_mem_wdata", busA.mem_wdata, 16'd0);
        chk("rst_out_data", busA.out_data, 16'd0);
        chk("rst_run_cycles", runA, 32'd0);
        @(posedge clk); #1;
        RESET_n = 1'b1;
        @(posedge clk); #1;

        // run 1: load 10,20,30,40 with gaps; dump 2..4 -> 30,40,4
        exp_out.push_back(16'd30);
        exp_out.push_back(16'd40);
        exp_out.push_back(16'd4);
        pulse_goA();
        chk("busy_after_go", busyA, 1'b1);
        chk("load_mux", muxA, 2'd1);
        load_a(16'd10, 16'd20, 16'd30, 16'd40);
        wait_startA();
        cores_a();
        wait_doneA();

        // run 2: restart from DONE; load 0..3 -> dump 2,3,4
        exp_out.push_back(16'd2);
        exp_out.push_back(16'd3);
        exp_out.push_back(16'd4);
        pulse_goA();
        chk("restart_done_cleared", doneA, 1'b0);
        load_a(16'd0, 16'd1, 16'd2, 16'd3);
        wait_startA();
        cores_a();
        wait_doneA();

        // run 3: reset while a dump word is presented and stalled
        rdy_mode = 1'b0;
        pulse_goA();
        load_a(16'd100, 16'd101, 16'd102, 16'd103);
        wait_startA();
        cores_a();
        t = 0;
        @(negedge clk);
        while (!busA.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("stall_out_valid", busA.out_valid, 1'b1);
        RESET_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", busA.out_valid, 1'b0);
        chk("rst_mid_busy", busyA, 1'b0);
        chk("rst_mid_mux", muxA, 2'd0);
        chk("rst_mid_mem_addr", busA.mem_addr, 16'd0);
        chk("rst_mid_out_data", busA.out_data, 16'd0);
        chk("rst_mid_run_cycles", runA, 32'd0);
        @(posedge clk); #1;
        RESET_n  = 1'b1;
        rdy_mode = 1'b1;
        @(posedge clk); #1;
        chk("after_rst_idle", busyA, 1'b0);

        // run 4: full sequence after the reset; load 5..8 -> dump 7,8,4
        exp_out.push_back(16'd7);
        exp_out.push_back(16'd8);
        exp_out.push_back(16'd4);
        pulse_goA();
        load_a(16'd5, 16'd6, 16'd7, 16'd8);
        wait_startA();
        cores_a();
        wait_doneA();

        // configuration B: SETTLE_CYC=0, empty dump window, go held high through RUN
        goB = 1'b1;
        @(posedge clk); #1;
        t = 0;
        @(negedge clk);
        while (!startB && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("b_start_delay", t, 4);
        repeat (3) @(posedge clk); #1;
        chk("b_go_ignored_busy", busyB, 1'b1);
        chk("b_go_ignored_in_ready", busB.in_ready, 1'b0);
        chk("b_go_ignored_start", startB, 1'b0);
        coreB = 2'b11;
        @(posedge clk); #1;
        goB   = 1'b0;
        coreB = 2'b00;
        chk("b_done", doneB, 1'b1);
        chk("b_busy", busyB, 1'b0);
        chk("b_run_cycles", runB, 32'd3);
        @(posedge clk); #1;
        chk("b_done_held", doneB, 1'b1);
        chk("b_mem_we", busB.mem_we, 1'b0);

        repeat (3) @(posedge clk);
        chk("exp_wr_drained", exp_wr.size(), 0);
        chk("exp_out_drained", exp_out.size(), 0);
        chk("b_no_out_valid", seenB_out, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/host_mem_sequencer.md
HOST_MEM_SEQUENCER -- requirements
Module: host_mem_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16: data memory word width.
REQ-002 SHALL have parameter ADDR_W, default 16: data memory address width.
REQ-003 SHALL have parameter LOAD_WORDS, default 1000: words written to memory in LOAD, starting at address 0.
REQ-004 SHALL have parameter DUMP_START, default 0, and DUMP_END, default 997: dump range, DUMP_START inclusive, DUMP_END exclusive.
REQ-005 SHALL have parameter NUM_CORES, default 4: number of core END inputs.
REQ-006 SHALL have parameter SETTLE_CYC, default 20: idle cycles between LOAD and START.
REQ-007 clk  input  1  single clock, all state on rising edge.
REQ-008 RESET_n  input  1  reset, asynchronous and active-low.
REQ-009 go  input  1  begin full sequence; sampled only in IDLE.
REQ-010 in_valid / in_data / in_ready  input / input DATA_W / output  load stream; a word transfers on a cycle with in_valid && in_ready.
REQ-011 out_valid / out_data / out_ready  output / output DATA_W / input  dump stream; a word transfers on a cycle with out_valid && out_ready.
REQ-012 mem_addr / mem_wdata / mem_we  output ADDR_W / DATA_W / 1  memory port; mem_rdata  input DATA_W, valid one cycle after mem_addr.
REQ-013 addr_mux_select  output  2  0 = cores own memory, 1 = load, 2 = dump.
REQ-014 START  output  1  one-cycle core start pulse.
REQ-015 core_end  input  NUM_CORES  per-core END level or pulse.
REQ-016 busy / done  output 1 / 1  sequence active / sequence finished.
REQ-017 run_cycles  output  32  cycles from START to all-cores-ended.

Function
REQ-018 States SHALL be IDLE, LOAD, SETTLE, KICK, RUN, DUMP_RD, DUMP_OUT, DONE.
REQ-019 IDLE: go=1 -> LOAD; load address counter cleared; busy=1 from next cycle.
REQ-020 LOAD: in_ready=1, addr_mux_select=1; each transfer drives mem_we=1, mem_addr=counter, mem_wdata=in_data in the same cycle; counter increments.
REQ-021 LOAD SHALL exit to SETTLE on the transfer of word LOAD_WORDS-1; in_ready=0 in all other states.
REQ-022 SETTLE: addr_mux_select=0, counts SETTLE_CYC cycles (SETTLE_CYC=0 -> straight to KICK next cycle).
REQ-023 KICK: START=1 for exactly one cycle, run_cycles cleared, per-core sticky end flags cleared; -> RUN.
REQ-024 RUN: end flag i set on any cycle core_end[i]=1; run_cycles increments each RUN cycle, saturating at all-ones.
REQ-025 RUN -> DUMP_RD on the cycle all NUM_CORES sticky flags are set; core_end pulses need not overlap.
REQ-026 DUMP_RD: addr_mux_select=2, mem_addr=dump pointer (starts DUMP_START); -> DUMP_OUT next cycle.
REQ-027 DUMP_OUT: out_valid=1, out_data=registered mem_rdata, held stable until out_ready; on transfer pointer increments, -> DUMP_RD, or -> DONE if pointer was DUMP_END-1.
REQ-028 DUMP_END <= DUMP_START SHALL skip dump: RUN -> DONE directly.
REQ-029 DONE: done=1, busy=0, addr_mux_select=0; run_cycles held; go=1 -> LOAD (restart, done cleared).
REQ-030 mem_we SHALL be 0 outside LOAD transfers; START SHALL be 0 outside KICK.
REQ-031 go asserted while busy SHALL be ignored.
REQ-032 Counters SHALL be ADDR_W wide; addresses wrap modulo 2^ADDR_W, no error flag.

Reset
REQ-033 RESET_n=0 SHALL immediately force IDLE and all outputs to 0: busy, done, START, mem_we, in_ready, out_valid, addr_mux_select, mem_addr, mem_wdata, out_data, run_cycles.
REQ-034 Reset mid-sequence SHALL abandon the sequence; no partial dump word delivered; first go after release restarts from LOAD.

Verification
REQ-035 LOAD_WORDS=4, stream 10,20,30,40 with in_valid gaps -> mem_we on exactly 4 cycles, addresses 0..3, data in order, addr_mux_select=1 throughout.
REQ-036 SETTLE_CYC=3 -> START high exactly one cycle, 4 cycles after last load transfer, addr_mux_select=0.
REQ-037 NUM_CORES=2, core_end[0] pulse 5 cycles after START, core_end[1] pulse 12 cycles after -> RUN exits after second pulse, run_cycles=12.
REQ-038 Memory preloaded 0..9 at addresses, DUMP_START=2, DUMP_END=5, out_ready toggling 1/0 -> out stream 2,3,4 each held while stalled, then done=1.
REQ-039 RESET_n low during DUMP_OUT with out_valid=1 -> out_valid=0 same instant, IDLE; new go reruns full sequence correctly.
REQ-040 go held high in RUN, and DUMP_END=DUMP_START -> go ignored, RUN -> DONE without any out_valid.
